// File: rtl/fir_pkg.sv
// Shared width helpers and the output rounding/saturation stage for the
// transposed-form FIR tap array.
package fir_pkg;

    localparam int unsigned RS_W = 64;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned acc_width(input int unsigned data_w,
                                              input int unsigned coef_w,
                                              input int unsigned n_taps);
        return data_w + coef_w + clog2(n_taps);
    endfunction

    // Round-half-up then clamp; acc arrives already sign/zero extended to RS_W.
    function automatic logic signed [RS_W-1:0] round_sat(input logic signed [RS_W-1:0] acc,
                                                         input int unsigned shift,
                                                         input int unsigned out_w,
                                                         input bit          sgn);
        logic signed [RS_W-1:0] v;
        logic signed [RS_W-1:0] hi;
        logic signed [RS_W-1:0] lo;
        v = acc;
        if (shift > 0) v = (v + (64'sd1 <<< (shift - 1))) >>> shift;
        if (sgn) begin
            hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
            lo = -(64'sd1 <<< (out_w - 1));
        end else begin
            hi = (64'sd1 <<< out_w) - 64'sd1;
            lo = '0;
        end
        if (v > hi)      v = hi;
        else if (v < lo) v = lo;
        return v;
    endfunction

endpackage

// File: rtl/fir_tap.sv
// One processing element of the transposed FIR: Yout <= Yin + Cin*Xin when enabled.
module fir_tap #(
    parameter int unsigned COEF_W = 6,
    parameter int unsigned ACC_W  = 13,
    parameter int unsigned SIGNED = 0
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              en,
    input  logic              clr,
    input  logic [COEF_W-1:0] Cin,
    input  logic [ACC_W-1:0]  Xin,
    input  logic [ACC_W-1:0]  Yin,
    output logic [ACC_W-1:0]  Yout
);

    logic [ACC_W-1:0] c_ext;
    logic [ACC_W-1:0] y_d;
    logic [ACC_W-1:0] y_q;

    // Xin is pre-extended by the top; truncated product is exact in two's complement.
    always_comb begin
        c_ext = (SIGNED != 0) ? {{(ACC_W-COEF_W){Cin[COEF_W-1]}}, Cin}
                              : {{(ACC_W-COEF_W){1'b0}}, Cin};
        y_d = y_q;
        if (clr)     y_d = '0;
        else if (en) y_d = Yin + c_ext * Xin;
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) y_q <= '0;
        else         y_q <= y_d;
    end

    assign Yout = y_q;

endmodule

// File: rtl/fir_tap_array.sv
// Streaming N-tap transposed-form FIR with run-time coefficients, rounding and
// saturation, valid/ready backpressure and a synchronous clear.
module fir_tap_array
    import fir_pkg::*;
#(
    parameter int unsigned N_TAPS = 8,
    parameter int unsigned DATA_W = 4,
    parameter int unsigned COEF_W = 6,
    parameter int unsigned OUT_W  = 4,
    parameter int unsigned SHIFT  = 7,
    parameter int unsigned SIGNED = 0,
    parameter logic [N_TAPS*COEF_W-1:0] COEF_INIT =
        {6'd4, 6'd12, 6'd25, 6'd34, 6'd34, 6'd25, 6'd12, 6'd4}
) (
    input  logic                     clk,
    input  logic                     nReset,
    input  logic                     clr,
    input  logic                     in_vld,
    output logic                     in_rdy,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic [OUT_W-1:0]         out_data,
    input  logic                     coef_we,
    input  logic [clog2(N_TAPS)-1:0] coef_addr,
    input  logic [COEF_W-1:0]        coef_wdata
);

    localparam int unsigned ACC_W = acc_width(DATA_W, COEF_W, N_TAPS);

    logic [COEF_W-1:0] coef_q [N_TAPS];
    logic [ACC_W-1:0]  r [1:N_TAPS-1];
    logic [ACC_W-1:0]  x_ext;
    logic [ACC_W-1:0]  c0_ext;
    logic [ACC_W-1:0]  acc;
    logic [RS_W-1:0]   acc_ext;
    logic [OUT_W-1:0]  data_rs;
    logic              adv;
    logic              out_vld_d, out_vld_q;
    logic [OUT_W-1:0]  out_data_d, out_data_q;

    always_comb begin
        x_ext   = (SIGNED != 0) ? {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data}
                                : {{(ACC_W-DATA_W){1'b0}}, in_data};
        c0_ext  = (SIGNED != 0) ? {{(ACC_W-COEF_W){coef_q[0][COEF_W-1]}}, coef_q[0]}
                                : {{(ACC_W-COEF_W){1'b0}}, coef_q[0]};
        acc     = c0_ext * x_ext + r[1];
        acc_ext = (SIGNED != 0) ? {{(RS_W-ACC_W){acc[ACC_W-1]}}, acc}
                                : {{(RS_W-ACC_W){1'b0}}, acc};
        data_rs = OUT_W'(round_sat(acc_ext, SHIFT, OUT_W, SIGNED != 0));
    end

    // clr outranks a pending sample: the sample stays on the bus unconsumed.
    always_comb begin
        in_rdy     = !clr && (!out_vld_q || out_rdy);
        adv        = in_vld && in_rdy;
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        if (clr) begin
            out_vld_d  = 1'b0;
            out_data_d = '0;
        end else if (adv) begin
            out_vld_d  = 1'b1;
            out_data_d = data_rs;
        end else if (out_rdy) begin
            out_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            for (int unsigned k = 0; k < N_TAPS; k++) coef_q[k] <= COEF_INIT[k*COEF_W +: COEF_W];
        end else if (coef_we && (32'(coef_addr) < N_TAPS)) begin
            coef_q[coef_addr] <= coef_wdata;
        end
    end

    for (genvar k = 1; k < N_TAPS; k++) begin : g_tap
        logic [ACC_W-1:0] yin;
        if (k == N_TAPS - 1) begin : g_last
            assign yin = '0;
        end else begin : g_mid
            assign yin = r[k+1];
        end
        fir_tap #(
            .COEF_W(COEF_W),
            .ACC_W (ACC_W),
            .SIGNED(SIGNED)
        ) u_tap (
            .clk   (clk),
            .nReset(nReset),
            .en    (adv),
            .clr   (clr),
            .Cin   (coef_q[k]),
            .Xin   (x_ext),
            .Yin   (yin),
            .Yout  (r[k])
        );
    end

    assign out_vld  = out_vld_q;
    assign out_data = out_data_q;

endmodule
